// File: rtl/gb_dma_pkg.sv
// Shared constants for the Game Boy DMA engines (OAM DMA now, HDMA later).
package gb_dma_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;

  localparam int OAM_BYTES = 160;

  localparam logic [15:0] DMA_REG_ADR = 16'hFF46;

  localparam logic [7:0] ECHO_BASE_HI = 8'hE0;
  localparam logic [7:0] ECHO_OFFSET  = 8'h20;

  // Echo RAM (0xE0xx and up) reads back the work RAM it mirrors at 0xC0-0xDF.
  function automatic logic [7:0] effSrcHi(input logic [7:0] srcHi);
    return (srcHi >= ECHO_BASE_HI) ? (srcHi - ECHO_OFFSET) : srcHi;
  endfunction

endpackage

// File: rtl/gb_dma_slot_ctr.sv
// Phase/index counter pair for byte-slot DMA engines; flags the last clock of a
// slot and the last clock of the final slot.
module gb_dma_slot_ctr
  import gb_dma_pkg::*;
#(
  parameter int CLKS_PER_BYTE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [7:0] idx_o,
  output logic       phaseLast_o,
  output logic       slotLast_o
);

  localparam int             PW     = $clog2(CLKS_PER_BYTE);
  localparam logic [PW-1:0]  P_LAST = PW'(CLKS_PER_BYTE - 1);
  localparam logic [7:0]     I_LAST = 8'(OAM_BYTES - 1);

  logic [PW-1:0] phase_q, phase_d;
  logic [7:0]    idx_q, idx_d;

  assign phaseLast_o = (phase_q == P_LAST);
  assign slotLast_o  = phaseLast_o && (idx_q == I_LAST);
  assign idx_o       = idx_q;

  always_comb begin
    phase_d = phase_q;
    idx_d   = idx_q;
    if (clr_i) begin
      phase_d = '0;
      idx_d   = '0;
    end else if (en_i) begin
      if (phaseLast_o) begin
        phase_d = '0;
        idx_d   = slotLast_o ? 8'd0 : idx_q + 8'd1;
      end else begin
        phase_d = phase_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_q <= '0;
      idx_q   <= '0;
    end else begin
      phase_q <= phase_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/gb_oam_dma.sv
// OAM DMA: copies 160 bytes from {src_hi, 8'h00} into OAM, one byte per
// M-cycle, after a CPU write to 0xFF46.
module gb_oam_dma
  import gb_dma_pkg::*;
#(
  parameter int CLKS_PER_BYTE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_wr,
  input  logic [7:0]  reg_din,
  output logic [7:0]  reg_dout,
  output logic [15:0] dma_adr,
  output logic        dma_rd,
  input  logic [7:0]  dma_din,
  output logic [7:0]  oam_adr,
  output logic [7:0]  oam_dout,
  output logic        oam_wr,
  output logic        dma_active,
  output logic        cpu_block
);

  logic [1:0] state_q, state_d;
  logic [7:0] srcHi_q, srcHi_d;
  logic [7:0] idx;
  logic       phaseLast, slotLast;
  logic       ctrClr, ctrEn;
  logic       inXfer;

  gb_dma_slot_ctr #(
    .CLKS_PER_BYTE(CLKS_PER_BYTE)
  ) u_slot_ctr (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (ctrClr),
    .en_i       (ctrEn),
    .idx_o      (idx),
    .phaseLast_o(phaseLast),
    .slotLast_o (slotLast)
  );

  // A register write always wins: it (re)starts the transfer from any state.
  always_comb begin
    state_d = state_q;
    srcHi_d = srcHi_q;
    ctrClr  = 1'b0;
    ctrEn   = 1'b0;
    if (reg_wr) begin
      state_d = ST_START;
      srcHi_d = reg_din;
      ctrClr  = 1'b1;
    end else begin
      case (state_q)
        ST_START: begin
          if (phaseLast) begin
            state_d = ST_XFER;
            ctrClr  = 1'b1;
          end else begin
            ctrEn = 1'b1;
          end
        end
        ST_XFER: begin
          if (slotLast) begin
            state_d = ST_IDLE;
            ctrClr  = 1'b1;
          end else begin
            ctrEn = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          ctrClr  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      srcHi_q <= 8'h00;
    end else begin
      state_q <= state_d;
      srcHi_q <= srcHi_d;
    end
  end

  assign inXfer     = (state_q == ST_XFER);
  assign dma_active = (state_q == ST_START) || inXfer;
  assign cpu_block  = inXfer;
  assign reg_dout   = srcHi_q;
  assign dma_rd     = inXfer;
  assign dma_adr    = inXfer ? {effSrcHi(srcHi_q), idx} : 16'h0000;
  assign oam_wr     = inXfer && phaseLast;
  assign oam_adr    = inXfer ? idx : 8'h00;
  assign oam_dout   = oam_wr ? dma_din : 8'h00;

endmodule

// File: tb/tb_gb_oam_dma.sv
// Directed bench for gb_oam_dma: a default (4 clk/byte) instance for the main
// scenarios and a 2 clk/byte instance for the fast build.
module tb_gb_oam_dma;

  logic        clk;
  logic        reset;
  logic        regWr, regWr2;
  logic [7:0]  regDin;

  logic [7:0]  regDout, regDout2;
  logic [15:0] dmaAdr, dmaAdr2;
  logic        dmaRd, dmaRd2;
  logic [7:0]  dmaDin, dmaDin2;
  logic [7:0]  oamAdr, oamAdr2;
  logic [7:0]  oamDout, oamDout2;
  logic        oamWr, oamWr2;
  logic        dmaActive, dmaActive2;
  logic        cpuBlock, cpuBlock2;

  int checks   = 0;
  int failures = 0;

  // Source memory model: each byte is its low address XOR 0x5A.
  assign dmaDin  = dmaAdr[7:0] ^ 8'h5A;
  assign dmaDin2 = dmaAdr2[7:0] ^ 8'h5A;

  gb_oam_dma u_dut (
    .clk(clk), .reset(reset), .reg_wr(regWr), .reg_din(regDin), .reg_dout(regDout),
    .dma_adr(dmaAdr), .dma_rd(dmaRd), .dma_din(dmaDin), .oam_adr(oamAdr),
    .oam_dout(oamDout), .oam_wr(oamWr), .dma_active(dmaActive), .cpu_block(cpuBlock)
  );

  gb_oam_dma #(.CLKS_PER_BYTE(2)) u_dut2 (
    .clk(clk), .reset(reset), .reg_wr(regWr2), .reg_din(regDin), .reg_dout(regDout2),
    .dma_adr(dmaAdr2), .dma_rd(dmaRd2), .dma_din(dmaDin2), .oam_adr(oamAdr2),
    .oam_dout(oamDout2), .oam_wr(oamWr2), .dma_active(dmaActive2), .cpu_block(cpuBlock2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Register write strobe; returns one sample point after the capturing edge.
  task automatic applyStimulus(input logic [7:0] v);
    regDin = v;
    regWr  = 1'b1;
    tick();
    regWr  = 1'b0;
  endtask

  // Follows a full 4 clk/byte transfer from sample point k=1 (first START clock)
  // through k=645 (first idle clock).
  task automatic watchCopy(input string tag, input logic [7:0] effHi);
    int wrCount, lastWrK, startErr, xferErr, timeErr, idx;
    wrCount = 0; lastWrK = 0; startErr = 0; xferErr = 0; timeErr = 0;
    for (int k = 1; k <= 645; k++) begin
      idx = (k - 5) / 4;
      if (k <= 4 && (dmaRd || oamWr || cpuBlock)) startErr++;
      if (k >= 5 && k <= 644) begin
        if (dmaRd !== 1'b1 || dmaAdr !== {effHi, 8'(idx)}) xferErr++;
      end
      if (k == 1) checkOutput({tag, "_active_rise"}, {31'd0, dmaActive}, 32'd1);
      if (k == 5) begin
        checkOutput({tag, "_first_adr"}, {16'd0, dmaAdr}, {16'd0, effHi, 8'h00});
        checkOutput({tag, "_cpu_block"}, {31'd0, cpuBlock}, 32'd1);
      end
      if (oamWr === 1'b1) begin
        wrCount++;
        lastWrK = k;
        if (!(k >= 5 && ((k - 5) % 4) == 3)) timeErr++;
        else if (oamAdr !== 8'(idx) || oamDout !== (8'(idx) ^ 8'h5A)) xferErr++;
      end
      if (k == 645) checkOutput({tag, "_active_fall"}, {31'd0, dmaActive}, 32'd0);
      if (k < 645) tick();
    end
    checkOutput({tag, "_start_quiet"}, startErr, 0);
    checkOutput({tag, "_xfer_errs"}, xferErr, 0);
    checkOutput({tag, "_wr_timing"}, timeErr, 0);
    checkOutput({tag, "_wr_count"}, wrCount, 160);
    checkOutput({tag, "_last_wr_k"}, lastWrK, 644);
  endtask

  initial begin
    int act, wr, last, err, bad;
    reset  = 1'b0;
    regWr  = 1'b0;
    regWr2 = 1'b0;
    regDin = 8'h00;
    repeat (3) tick();
    checkOutput("rst_active", {31'd0, dmaActive}, 0);
    checkOutput("rst_block", {31'd0, cpuBlock}, 0);
    checkOutput("rst_adr", {16'd0, dmaAdr}, 0);
    checkOutput("rst_rd", {31'd0, dmaRd}, 0);
    checkOutput("rst_oam", {15'd0, oamWr, oamAdr, oamDout}, 0);
    checkOutput("rst_dout", {24'd0, regDout}, 0);
    checkOutput("rst2_active", {31'd0, dmaActive2}, 0);
    reset = 1'b1;
    tick();

    applyStimulus(8'hC1);
    checkOutput("basic_dout", {24'd0, regDout}, 32'hC1);
    watchCopy("basic", 8'hC1);

    applyStimulus(8'hFE);
    checkOutput("echo_dout", {24'd0, regDout}, 32'hFE);
    watchCopy("echo", 8'hDE);

    // Restart in the middle of byte 50.
    applyStimulus(8'h80);
    repeat (205) tick();
    checkOutput("restart_mid_adr", {16'd0, dmaAdr}, 32'h8032);
    applyStimulus(8'h90);
    checkOutput("restart_dout", {24'd0, regDout}, 32'h90);
    watchCopy("restart", 8'h90);

    // Restart on the very last clock of the last slot; that byte is still written.
    applyStimulus(8'hC1);
    repeat (643) tick();
    regDin = 8'hC2;
    regWr  = 1'b1;
    #1;
    checkOutput("restart_last_wr", {31'd0, oamWr}, 1);
    checkOutput("restart_last_adr", {24'd0, oamAdr}, 32'h9F);
    checkOutput("restart_last_data", {24'd0, oamDout}, 32'hC5);
    tick();
    regWr = 1'b0;
    watchCopy("relast", 8'hC2);

    // Reset at the start of byte 10.
    applyStimulus(8'hC1);
    repeat (44) tick();
    checkOutput("abort_pre_adr", {16'd0, dmaAdr}, 32'hC10A);
    reset = 1'b0;
    tick();
    checkOutput("abort_active", {31'd0, dmaActive}, 0);
    checkOutput("abort_block", {31'd0, cpuBlock}, 0);
    checkOutput("abort_adr", {16'd0, dmaAdr}, 0);
    checkOutput("abort_dout", {24'd0, regDout}, 0);
    bad = 0;
    repeat (8) begin
      if (oamWr !== 1'b0 || dmaActive !== 1'b0) bad++;
      tick();
    end
    reset = 1'b1;
    repeat (8) begin
      if (oamWr !== 1'b0 || dmaActive !== 1'b0) bad++;
      tick();
    end
    checkOutput("abort_quiet", bad, 0);

    // Fast build: 2 clocks per byte.
    regDin = 8'h40;
    regWr2 = 1'b1;
    tick();
    regWr2 = 1'b0;
    act = 0; wr = 0; last = 0; err = 0;
    for (int k = 1; k <= 323; k++) begin
      if (dmaActive2 === 1'b1) act++;
      if (k >= 3 && k <= 322 && dmaAdr2 !== {8'h40, 8'((k - 3) / 2)}) err++;
      if (oamWr2 === 1'b1) begin
        wr++;
        last = k;
        if (!(k >= 3 && ((k - 3) % 2) == 1)) err++;
        else if (oamAdr2 !== 8'((k - 3) / 2)) err++;
      end
      if (k < 323) tick();
    end
    checkOutput("fast_active_clks", act, 322);
    checkOutput("fast_wr_count", wr, 160);
    checkOutput("fast_last_wr_k", last, 322);
    checkOutput("fast_errs", err, 0);
    checkOutput("fast_idle", {31'd0, dmaActive2}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gb_oam_dma.md
Name: gb_oam_dma

Overview:
Bus-initiator counterpart to the address decoder. It generates source read addresses on the system bus, which the memory map decodes into cartridge/VRAM/RAM selects, and writes the returned bytes into OAM. A CPU write to I/O register 0xFF46 starts the transfer. The block copies 160 bytes from {src_hi, 8'h00} to OAM 0x00-0x9F, one byte per M-cycle, and flags the bus-conflict window to the CPU interface.

Parameters:
CLKS_PER_BYTE, 4, clocks per transferred byte (one M-cycle); legal range 2..16
OAM_BYTES, 160, bytes per transfer

Ports:
clk  in  1  system clock
reset  in  1  reset, synchronous, active-low
reg_wr  in  1  one-clock strobe: CPU writes 0xFF46 (io select and address decode done upstream)
reg_din  in  8  CPU write data (source high byte)
reg_dout  out  8  readback of the last value written to 0xFF46
dma_adr  out  16  source read address driven onto the system bus
dma_rd  out  1  source read request; dma_adr is valid while high
dma_din  in  8  source read data; valid in the last clock of each byte slot
oam_adr  out  8  OAM write index
oam_dout  out  8  OAM write data
oam_wr  out  1  OAM write enable; OAM captures on the rising clk edge
dma_active  out  1  high in START and XFER
cpu_block  out  1  high in XFER only; the CPU interface must restrict the CPU to HRAM while this is high

Behaviour:
- Reset (reset==0 sampled at clk): state=IDLE, reg_dout=8'h00, index=0, phase=0. All outputs are 0, including dma_adr=16'h0000.
- State machine with states IDLE, START and XFER. Phase counter p runs 0..CLKS_PER_BYTE-1. Byte index i runs 0..OAM_BYTES-1.
- Transitions:
  - IDLE, reg_wr=1: latch src_hi=reg_din and reg_dout=reg_din; go to START with p=0.
  - START: lasts CLKS_PER_BYTE clocks, then goes to XFER with i=0 and p=0.
  - XFER: p increments each clock. When p wraps, i increments. After the slot with i=OAM_BYTES-1 and p=CLKS_PER_BYTE-1, go to IDLE.
- Source mapping: if src_hi >= 8'hE0, the effective high byte is src_hi-8'h20 (echo RAM maps to 0xC0-0xDF). Otherwise the effective high byte is src_hi. reg_dout always returns the raw written value.
- XFER outputs (all combinational from state, i and p):
  - dma_rd=1 and dma_adr={eff_hi, i[7:0]} for every clock of the slot.
  - oam_wr=1 only when p==CLKS_PER_BYTE-1, with oam_adr=i and oam_dout=dma_din.
- Outside XFER: dma_rd=0, oam_wr=0, dma_adr=0, oam_adr=0, oam_dout=0.
- Latency: reg_wr at edge t gives dma_active=1 from t+1. First dma_rd at t+1+CLKS_PER_BYTE. Last oam_wr at t+CLKS_PER_BYTE*(OAM_BYTES+1). dma_active falls the clock after that.
- Restart: reg_wr in START or XFER (including the last clock of the last slot) latches the new src_hi and re-enters START with p=0 and i=0. An oam_wr in that same clock still happens. No partial completion is signalled.
- Reset mid-transfer aborts immediately. No further oam_wr; outputs return to reset values at the next edge.
- Counter widths: i is 8 bits and never exceeds OAM_BYTES-1. p is $clog2(CLKS_PER_BYTE) bits. No wrap past OAM 0x9F is possible.

Decomposition:
- Shared package gb_dma_pkg holds:
  - state encoding localparams (IDLE=0, START=1, XFER=2);
  - OAM_BYTES=160;
  - DMA_REG_ADR=16'hFF46;
  - ECHO_BASE_HI=8'hE0 and ECHO_OFFSET=8'h20.
- Decoding 0xFF46 stays in the I/O register decoder upstream; this block sees only reg_wr.
- One natural sub-module: gb_dma_slot_ctr, the phase/index counter pair with wrap and terminal flags, reused by the future HDMA block.

Test Plan:
- Reset with transfers idle: hold reset=0 for 3 clocks -> all outputs 0, reg_dout=8'h00.
- Basic copy, src 0xC1, source memory model returns byte = low address ^ 8'h5A -> 160 oam_wr pulses, oam_adr 0x00..0x9F, oam_dout=adr[7:0]^8'h5A. First dma_adr=16'hC100 at t+5, last oam_wr at t+644, dma_active low at t+645.
- Echo mapping, write 0xFE -> dma_adr runs 0xDE00..0xDE9F; reg_dout=8'hFE.
- Restart mid-XFER, write 0x80 at byte 50 slot then 0x90 -> four clocks of START, then dma_adr restarts at 0x9000 with oam_adr 0. No oam_wr during START. 160 further writes.
- Reset mid-transfer at byte 10 -> no oam_wr after the reset edge; dma_active=0, cpu_block=0.
- CLKS_PER_BYTE=2 build -> oam_wr every 2nd clock; total active time 322 clocks.
